// File: rtl/punc_datapath.sv
// punc_datapath: datapath of the PUnC LC3 processor.
//
// Executes the per-cycle select/load strobes issued by the PUnC control FSM.
// It has no sequencing of its own: every register holds its value unless one
// of its strobes is asserted, and rst overrides every strobe.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   mem_*             external word memory: combinational read at mem_addr,
//                     mem_w_en is a pass-through of w_en_MEM
//   PC_* / IR_ld      program counter and instruction register control
//   addr_MEM_sel      memory address: 00 PC, 01 PC-adder, 10 store_reg, 11 ALU
//   *_RF, w_RF_sel    8x16 register file: 2 read ports, 1 debug read, 1 write
//   sext_data, A_sel, B_sel, ALU_sel   ALU operand and operation selects
//   NZP_sel, N_ld, Z_ld, P_ld          condition code source and loads
//   store_ld          store_reg <= mem_r_data (indirection for LDI/STI)
//   IR, RF_data, n, z, p, PC           status and debug back to control
//
// Handshake: there is none. Strobes are level signals sampled on every
// posedge; the combinational value selected in a cycle is captured at the
// end of that same cycle.
module punc_datapath #(
    parameter logic [15:0] PC_RESET = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_w_data,
    output logic        mem_w_en,
    input  logic [15:0] mem_r_data,
    input  logic        PC_data_sel,
    input  logic        PC_add_sel,
    input  logic        PC_ld,
    input  logic        PC_clr,
    input  logic        PC_inc,
    input  logic        IR_ld,
    input  logic [1:0]  addr_MEM_sel,
    input  logic        w_en_MEM,
    input  logic [1:0]  w_RF_sel,
    input  logic [2:0]  r_addr_0_RF,
    input  logic [2:0]  r_addr_1_RF,
    input  logic [2:0]  r_addr_2_RF,
    input  logic [2:0]  w_addr_RF,
    input  logic        w_en_RF,
    input  logic        rst_RF,
    input  logic        sext_data,
    input  logic        A_sel,
    input  logic        B_sel,
    input  logic [1:0]  ALU_sel,
    input  logic        NZP_sel,
    input  logic        N_ld,
    input  logic        Z_ld,
    input  logic        P_ld,
    input  logic        store_ld,
    output logic [15:0] IR,
    output logic [15:0] RF_data,
    output logic        n,
    output logic        z,
    output logic        p,
    output logic [15:0] PC
);

    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] store_q, store_d;
    logic [15:0] rf_q [0:7];
    logic [15:0] rf_d [0:7];
    logic        n_q, n_d, z_q, z_d, p_q, p_d;

    logic [15:0] rf_r_data_0, rf_r_data_1;
    logic [15:0] pc_offset, pc_adder;
    logic [15:0] imm, alu_a, alu_b, alu_res;
    logic [15:0] rf_w_data, flag_src;
    logic        calc_n, calc_z, calc_p;

    // Combinational reads; a same-cycle write is only seen next cycle.
    assign rf_r_data_0 = rf_q[r_addr_0_RF];
    assign rf_r_data_1 = rf_q[r_addr_1_RF];

    // PC-relative offsets: 11 bits for JSR, 9 bits for BR/LD/LDI/LEA/ST/STI.
    assign pc_offset = PC_add_sel ? {{7{ir_q[8]}}, ir_q[8:0]}
                                  : {{5{ir_q[10]}}, ir_q[10:0]};
    assign pc_adder  = pc_q + pc_offset;   // wraps modulo 2^16

    // imm5 for ADD/AND, offset6 for LDR/STR.
    assign imm   = sext_data ? {{10{ir_q[5]}}, ir_q[5:0]}
                             : {{11{ir_q[4]}}, ir_q[4:0]};
    assign alu_a = A_sel ? rf_r_data_0 : pc_q;
    assign alu_b = B_sel ? imm : rf_r_data_1;

    always_comb begin
        alu_res = alu_a;
        unique case (ALU_sel)
            2'b00:   alu_res = alu_a + alu_b;   // carry-out dropped
            2'b01:   alu_res = alu_a & alu_b;
            2'b10:   alu_res = alu_a;
            default: alu_res = ~alu_a;
        endcase
    end

    always_comb begin
        rf_w_data = pc_q;
        unique case (w_RF_sel)
            2'b00:   rf_w_data = pc_q;
            2'b01:   rf_w_data = mem_r_data;
            2'b10:   rf_w_data = alu_res;
            default: rf_w_data = pc_adder;
        endcase
    end

    always_comb begin
        mem_addr = pc_q;
        unique case (addr_MEM_sel)
            2'b00:   mem_addr = pc_q;
            2'b01:   mem_addr = pc_adder;
            2'b10:   mem_addr = store_q;
            default: mem_addr = alu_res;
        endcase
    end

    assign mem_w_data = rf_r_data_1;
    assign mem_w_en   = w_en_MEM;

    // Exactly one of calc_n/calc_z/calc_p is set for any value.
    assign flag_src = NZP_sel ? mem_r_data : alu_res;
    assign calc_n   = flag_src[15];
    assign calc_z   = (flag_src == 16'h0000);
    assign calc_p   = !flag_src[15] && !calc_z;

    always_comb begin
        pc_d = pc_q;
        if (PC_clr) begin
            pc_d = PC_RESET;
        end else if (PC_ld) begin
            pc_d = PC_data_sel ? rf_r_data_0 : pc_adder;
        end else if (PC_inc) begin
            pc_d = pc_q + 16'd1;
        end

        ir_d    = IR_ld    ? mem_r_data : ir_q;
        store_d = store_ld ? mem_r_data : store_q;
        n_d     = N_ld ? calc_n : n_q;
        z_d     = Z_ld ? calc_z : z_q;
        p_d     = P_ld ? calc_p : p_q;

        rf_d = rf_q;
        if (rst_RF) begin
            for (int i = 0; i < 8; i++) begin
                rf_d[i] = 16'h0000;
            end
        end else if (w_en_RF) begin
            rf_d[w_addr_RF] = rf_w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= PC_RESET;
            ir_q    <= 16'h0000;
            store_q <= 16'h0000;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            p_q     <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= 16'h0000;
            end
        end else begin
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            store_q <= store_d;
            n_q     <= n_d;
            z_q     <= z_d;
            p_q     <= p_d;
            rf_q    <= rf_d;
        end
    end

    // Debug read is forced to zero while rst is held, before the first edge
    // has cleared the array.
    assign RF_data = rst ? 16'h0000 : rf_q[r_addr_2_RF];
    assign IR      = ir_q;
    assign PC      = pc_q;
    assign n       = n_q;
    assign z       = z_q;
    assign p       = p_q;

endmodule

// File: doc/punc_datapath.md
Name: punc_datapath

Overview:
- Datapath for the PUnC LC3 processor: PC, IR, 8x16 register file, ALU, PC-offset adder, NZP flags, indirection (store) register, memory address/data muxing.
- Executes the per-cycle select/load strobes driven by the PUnC control FSM.
- Returns IR, condition codes and debug register data to that FSM.
- Sits between the control unit and an external 16-bit word memory: combinational read, write on clock edge.

Parameters:
PC_RESET, 16'h0000, PC value after rst or PC_clr

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous active-high reset
mem_addr  output  16  memory word address
mem_w_data  output  16  memory write data, always rf_r_data_1
mem_w_en  output  1  pass-through of w_en_MEM
mem_r_data  input  16  combinational memory read data at mem_addr
PC_data_sel  input  1  PC load source: 0 = PC-adder result, 1 = rf_r_data_0
PC_add_sel  input  1  PC-adder offset: 0 = sext(IR[10:0]), 1 = sext(IR[8:0])
PC_ld  input  1  load PC from PC_data_sel source
PC_clr  input  1  PC <= PC_RESET
PC_inc  input  1  PC <= PC+1
IR_ld  input  1  IR <= mem_r_data
addr_MEM_sel  input  2  00 PC, 01 PC-adder result, 10 store_reg, 11 ALU result
w_en_MEM  input  1  memory write enable
w_RF_sel  input  2  RF write data: 00 PC, 01 mem_r_data, 10 ALU result, 11 PC-adder result
r_addr_0_RF  input  3  read port 0 address
r_addr_1_RF  input  3  read port 1 address
r_addr_2_RF  input  3  debug read port address
w_addr_RF  input  3  write address
w_en_RF  input  1  register write enable
rst_RF  input  1  clear all 8 registers
sext_data  input  1  immediate: 0 = sext(IR[4:0]), 1 = sext(IR[5:0])
A_sel  input  1  ALU A: 0 PC, 1 rf_r_data_0
B_sel  input  1  ALU B: 0 rf_r_data_1, 1 selected immediate
ALU_sel  input  2  00 A+B, 01 A&B, 10 A, 11 ~A
NZP_sel  input  1  flag source: 0 ALU result, 1 mem_r_data
N_ld  input  1  load n flag
Z_ld  input  1  load z flag
P_ld  input  1  load p flag
store_ld  input  1  store_reg <= mem_r_data
IR  output  16  instruction register
RF_data  output  16  register[r_addr_2_RF], combinational
n  output  1  negative flag
z  output  1  zero flag
p  output  1  positive flag
PC  output  16  program counter, debug

Behaviour:
- Reset (rst=1 at posedge): PC=PC_RESET, IR=0, R0..R7=0, store_reg=0, n=z=p=0. rst overrides every other strobe in that cycle.
- Outputs while rst is held: RF_data=0, mem_w_en follows w_en_MEM. Control is responsible for holding w_en_MEM low during reset.
- All register updates occur on posedge. All muxes, ALU, adder and memory read are combinational, so a value selected in cycle N is captured at the end of cycle N.
- PC priority: PC_clr > PC_ld > PC_inc. PC arithmetic is modulo 2^16: 16'hFFFF+1 = 16'h0000; adder overflow wraps.
- PC-adder = PC + sext(offset), using the current registered PC. That PC is already incremented by the control unit during fetch.
- Register file: 2 read ports plus 1 debug read port, all combinational; 1 write port.
  - Write-then-read of the same address in one cycle: reads return the old value; the new value is visible the next cycle.
  - rst_RF has priority over w_en_RF.
- ALU is 16-bit. ADD discards carry-out.
- Flags: V = NZP_sel ? mem_r_data : ALU result. Computed n = V[15]; z = (V==0); p = !V[15] && V!=0.
  - Each of n/z/p updates only when its own _ld strobe is high.
  - Exactly one computed flag is 1.
- mem_w_en = w_en_MEM combinationally. mem_addr is driven by addr_MEM_sel regardless of mem_w_en.
- IR_ld and store_ld both sample mem_r_data. Both may be asserted in the same cycle; each loads independently.
- No internal FSM: sequencing is owned by control. Every register must hold its value when none of its strobes is asserted.

Test Plan:
- Reset: PC_RESET=16'h3000, assert rst with PC_inc=1 and w_en_RF=1 -> after release PC=16'h3000, IR=0, RF_data=0 for all r_addr_2_RF, n=z=p=0.
- Fetch/ADD:
  - Stimulus: mem[16'h3000]=16'h1261 (ADD R1,R1,#1), R1=16'hFFFF; fetch strobes, then ADD strobes (A_sel=1, B_sel=1, sext_data=0, ALU_sel=00, w_RF_sel=10, N/Z/P_ld=1).
  - Required: IR=16'h1261, PC=16'h3001, R1=0, z=1, n=p=0.
- LDI indirection:
  - Stimulus: IR offset9=2, PC=16'h3001, mem[16'h3003]=16'h4000, mem[16'h4000]=16'h8001. Cycle 1: addr_MEM_sel=01, store_ld. Cycle 2: addr_MEM_sel=10, w_RF_sel=01, NZP_sel=1.
  - Required: Rdst=16'h8001, n=1.
- JMP/BR:
  - JMP: PC_ld with PC_data_sel=1 and R2=16'h5000 -> PC=16'h5000.
  - BR: PC_ld with PC_data_sel=0, PC_add_sel=1, IR[8:0]=9'h1FF -> PC decrements by 1.
- Priority/wrap:
  - PC=16'hFFFF with PC_inc -> 16'h0000.
  - PC_clr+PC_ld+PC_inc together -> PC_RESET.
  - rst_RF+w_en_RF together -> all registers 0.
- Same-cycle write/read: write R3=16'h00AA while r_addr_0_RF=3 -> old value that cycle, 16'h00AA the next cycle. STR: mem_w_data=R[r_addr_1], mem_addr=ALU result with addr_MEM_sel=11.
